// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and state encoding for the pipeline controller
//
// Contents:
//   ST_IFID..ST_MEMWB : bit index of each pipeline register in the hold/clear vectors
//   DEF_RA_W          : default register-address width
//   state_t           : controller FSM states (S_RUN, S_DRAIN)
package pipe_ctrl_pkg;

  localparam int ST_IFID  = 0;
  localparam int ST_IDEX  = 1;
  localparam int ST_EXMEM = 2;
  localparam int ST_MEMWB = 3;

  localparam int DEF_RA_W = 5;

  // S_DRAIN: a fetch issued on the wrong path is still outstanding and its
  // response must be dropped at IF/ID when it returns.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard inputs and stage control outputs of the pipeline controller
//
// Signals (slave = controller side, master = pipeline side):
//   if_busy, ex_busy, mem_busy         : outstanding fetch / multicycle EX / data access
//   id_rs1_en, id_rs2_en               : ID stage reads rs1 / rs2
//   id_rs1_addr, id_rs2_addr           : ID source register addresses
//   ex_load, ex_rd_addr                : EX instruction is a load and its destination
//   ex_redirect, trap                  : PC redirect from EX, trap taken at MEM
//   hold, clear                        : per pipeline register hold / bubble
//   pc_hold                            : freeze PC
//   stall_cycles, flush_cnt            : saturating performance counters
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = 32,
  parameter int RA_W   = DEF_RA_W
);

  logic              if_busy;
  logic              ex_busy;
  logic              mem_busy;
  logic              id_rs1_en;
  logic              id_rs2_en;
  logic [RA_W-1:0]   id_rs1_addr;
  logic [RA_W-1:0]   id_rs2_addr;
  logic              ex_load;
  logic [RA_W-1:0]   ex_rd_addr;
  logic              ex_redirect;
  logic              trap;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] clear;
  logic              pc_hold;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output if_busy, ex_busy, mem_busy,
    output id_rs1_en, id_rs2_en, id_rs1_addr, id_rs2_addr,
    output ex_load, ex_rd_addr, ex_redirect, trap,
    input  hold, clear, pc_hold, stall_cycles, flush_cnt
  );

  modport slave (
    input  if_busy, ex_busy, mem_busy,
    input  id_rs1_en, id_rs2_en, id_rs1_addr, id_rs2_addr,
    input  ex_load, ex_rd_addr, ex_redirect, trap,
    output hold, clear, pc_hold, stall_cycles, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_det.sv
// rtl/pipe_hazard_det.sv - load-use hazard compare between EX destination and ID sources
//
// Ports:
//   i_ex_load    : EX instruction is a load
//   i_ex_rd_addr : EX destination register
//   i_rs1_en     : ID reads rs1
//   i_rs1_addr   : ID rs1 address
//   i_rs2_en     : ID reads rs2
//   i_rs2_addr   : ID rs2 address
//   o_hazard     : ID consumes the load result before it is available
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = DEF_RA_W
) (
  input  logic            i_ex_load,
  input  logic [RA_W-1:0] i_ex_rd_addr,
  input  logic            i_rs1_en,
  input  logic [RA_W-1:0] i_rs1_addr,
  input  logic            i_rs2_en,
  input  logic [RA_W-1:0] i_rs2_addr,
  output logic            o_hazard
);

  logic w_rd_nonzero;
  logic w_rs1_match;
  logic w_rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_rd_nonzero = (i_ex_rd_addr != '0);
  assign w_rs1_match  = i_rs1_en && (i_rs1_addr == i_ex_rd_addr);
  assign w_rs2_match  = i_rs2_en && (i_rs2_addr == i_ex_rd_addr);
  assign o_hazard     = i_ex_load && w_rd_nonzero && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central stall/bubble/flush controller for the IF/ID..MEM/WB registers
//
// Ports:
//   clk : clock, all state updates on rising edge
//   rst : asynchronous active-high reset
//   bus : pipe_ctrl_if.slave - hazard inputs, hold/clear/pc_hold outputs, counters
//
// hold/clear/pc_hold are combinational from state and inputs (zero latency).
// STAGES must be at least 4; registers above MEM/WB are never held or cleared.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = 32,
  parameter int RA_W   = DEF_RA_W
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_clear;
  logic              w_pc_hold;
  logic              w_flush;
  logic              w_load_use;

  pipe_hazard_det #(
    .RA_W (RA_W)
  ) u_hazard (
    .i_ex_load    (bus.ex_load),
    .i_ex_rd_addr (bus.ex_rd_addr),
    .i_rs1_en     (bus.id_rs1_en),
    .i_rs1_addr   (bus.id_rs1_addr),
    .i_rs2_en     (bus.id_rs2_en),
    .i_rs2_addr   (bus.id_rs2_addr),
    .o_hazard     (w_load_use)
  );

  always_comb begin
    w_hold       = '0;
    w_clear      = '0;
    w_pc_hold    = 1'b0;
    w_flush      = 1'b0;
    w_next_state = r_state;

    if (rst) begin
      // Bubble every register and freeze the PC while reset is held.
      w_clear   = '1;
      w_pc_hold = 1'b1;
    end else if (r_state == S_RUN) begin
      if (bus.trap) begin
        // Trap beats redirect and all stalls; instructions younger than MEM are killed.
        w_clear[ST_EXMEM:ST_IFID] = '1;
        w_flush                   = 1'b1;
        w_next_state              = bus.if_busy ? S_DRAIN : S_RUN;
      end else if (bus.mem_busy) begin
        w_hold[ST_EXMEM:ST_IFID] = '1;
        w_clear[ST_MEMWB]        = 1'b1;
        w_pc_hold                = 1'b1;
      end else if (bus.ex_busy) begin
        // A redirect from a still-busy EX instruction waits until it completes.
        w_hold[ST_IDEX:ST_IFID] = '1;
        w_clear[ST_EXMEM]       = 1'b1;
        w_pc_hold               = 1'b1;
      end else if (bus.ex_redirect) begin
        w_clear[ST_IDEX:ST_IFID] = '1;
        w_flush                  = 1'b1;
        w_next_state             = bus.if_busy ? S_DRAIN : S_RUN;
      end else if (w_load_use) begin
        w_hold[ST_IFID]  = 1'b1;
        w_clear[ST_IDEX] = 1'b1;
        w_pc_hold        = 1'b1;
      end else if (bus.if_busy) begin
        w_clear[ST_IFID] = 1'b1;
        w_pc_hold        = 1'b1;
      end
    end else begin
      // S_DRAIN: IF/ID keeps being bubbled so the stale response never reaches ID,
      // including the cycle it returns.
      w_clear[ST_IFID] = 1'b1;
      w_pc_hold        = 1'b1;
      if (!bus.if_busy) begin
        w_next_state = S_RUN;
      end
      if (bus.trap) begin
        w_clear[ST_EXMEM:ST_IFID] = '1;
        w_pc_hold                 = 1'b0;
        w_flush                   = 1'b1;
        w_next_state              = S_DRAIN;
      end else if (bus.mem_busy) begin
        // IF/ID is cleared rather than held, so only ID/EX and EX/MEM are held.
        w_hold[ST_EXMEM:ST_IDEX] = '1;
        w_clear[ST_MEMWB]        = 1'b1;
      end else if (bus.ex_busy) begin
        w_hold[ST_IDEX]   = 1'b1;
        w_clear[ST_EXMEM] = 1'b1;
      end
      // ex_redirect is ignored here: EX holds the bubble inserted by the earlier flush.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_stall_cycles <= '0;
      r_flush_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pc_hold && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.hold         = w_hold;
  assign bus.clear        = w_clear;
  assign bus.pc_hold      = w_pc_hold;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller that drives the per-stage `hold`/`clear` inputs of the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
It resolves the following into per-stage stall/bubble/flush commands:
- load-use hazards;
- multicycle EX units;
- outstanding memory and fetch accesses;
- EX-stage redirects and traps.

A small FSM discards wrong-path fetches that are still in flight. Saturating counters record stall and flush events for performance analysis.

Parameters:
STAGES, 4, number of pipeline registers controlled; index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
CNT_W, 32, width of performance counters
RA_W, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
if_busy  in  1  instruction fetch outstanding; IF output not valid this cycle
ex_busy  in  1  multicycle unit (mul/div) in EX not finished
mem_busy  in  1  data access in MEM outstanding
id_rs1_en, id_rs2_en  in  1 each  ID stage reads rs1/rs2
id_rs1_addr, id_rs2_addr  in  RA_W each  ID source registers
ex_load  in  1  instruction in EX is a load
ex_rd_addr  in  RA_W  EX destination register
ex_redirect  in  1  EX resolved taken branch/jump or mispredict; PC loads target this cycle
trap  in  1  exception/interrupt taken at MEM; PC loads trap vector
hold  out  STAGES  per-register hold
clear  out  STAGES  per-register clear (bubble)
pc_hold  out  1  freeze PC
stall_cycles  out  CNT_W  cycles with pc_hold=1
flush_cnt  out  CNT_W  redirect+trap events

Behaviour:
- States:
  - RUN.
  - DRAIN: a wrong-path fetch is in flight.
- Reset: state=RUN, counters=0. While rst=1, outputs are forced to clear=all ones, hold=0, pc_hold=1.
- Outputs are combinational from state and inputs; zero latency.
- Invariant: hold[i] and clear[i] are never both 1.
- Priority, highest first; only the first matching row applies in RUN:
  1. trap:
     - clear[2:0]=all ones, pc_hold=0, flush_cnt++.
     - next state = DRAIN if if_busy, else RUN.
  2. mem_busy:
     - hold[2:0]=all ones, clear[3]=1, pc_hold=1.
  3. ex_busy:
     - hold[1:0]=all ones, clear[2]=1, pc_hold=1.
  4. ex_redirect:
     - clear[1:0]=all ones, pc_hold=0, flush_cnt++.
     - next state = DRAIN if if_busy, else RUN.
  5. load-use: ex_load && ex_rd_addr!=0 && ((id_rs1_en && id_rs1_addr==ex_rd_addr) || (id_rs2_en && id_rs2_addr==ex_rd_addr)).
     - hold[0]=1, clear[1]=1, pc_hold=1.
  6. if_busy:
     - clear[0]=1, pc_hold=1.
  7. otherwise: all hold/clear=0, pc_hold=0.
- DRAIN state:
  - clear[0]=1 and pc_hold=1 every cycle, so the stale fetch never enters ID.
  - Exit: in the cycle if_busy=0 (stale response returns), clear[0] stays 1 and next state=RUN.
  - trap in DRAIN: apply row 1 outputs, stay in DRAIN.
  - mem_busy/ex_busy in DRAIN: hold the corresponding upper stages as in rows 2/3. clear[0] and pc_hold remain 1.
  - ex_redirect in DRAIN: ignore (the EX stage holds a bubble).
- Simultaneous events:
  - trap beats redirect; only one flush_cnt increment per cycle.
  - ex_redirect with ex_busy: the redirect waits until ex_busy=0.
- stall_cycles increments in every non-reset cycle with pc_hold=1.
- Both counters saturate at all ones and do not wrap.
- rst asserted mid-DRAIN: returns to RUN immediately (asynchronous reset).

Decomposition:
- Shared defines: stage index constants (ST_IFID..ST_MEMWB), state encoding (S_RUN, S_DRAIN), RA_W.
- Sub-module pipe_hazard_det: combinational load-use compare producing one bit. It is instantiated once and is reusable for the future forwarding unit.

Test Plan:
- Load-use: ex_load=1, ex_rd_addr=5, id_rs1_en=1, id_rs1_addr=5 for 1 cycle -> hold=0001, clear=0010, pc_hold=1, stall_cycles 0->1. Same stimulus with ex_rd_addr=0 -> all zeros.
- ex_busy for 3 cycles with mem_busy=0 -> hold=0011, clear=0100, pc_hold=1 each cycle; stall_cycles=3.
- ex_redirect=1 with if_busy=1, then if_busy stays 1 for 2 cycles and drops -> cycle0 clear=0011, pc_hold=0, flush_cnt=1. Next 3 cycles (DRAIN) clear=0001, pc_hold=1. Then RUN with outputs 0.
- trap and ex_redirect together with mem_busy=1 -> clear=0111, hold=0000, pc_hold=0, flush_cnt increments by exactly 1.
- Counter saturation: CNT_W=4 with pc_hold forced for 20 cycles -> stall_cycles holds at 15.
- Assert rst asynchronously while in DRAIN -> immediately clear=1111, pc_hold=1, counters 0. After release, state=RUN.
